// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state type and address-width helper for the multiport register file
package regfile_pkg;
    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: read/write/scoreboard bus of the register file
//   master (decode/writeback side): drives rd_addr, wr_*, sb_set_*; sees ready, rd_data, rd_busy
//   slave  (register file): the reverse
interface regfile_multiport_if #(
    parameter int DW     = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
);
    import regfile_pkg::*;
    localparam int AW = clog2(DEPTH);
    logic                 ready;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic                 sb_set_en;
    logic [AW-1:0]        sb_set_addr;

    modport master (
        input  ready, rd_data, rd_busy,
        output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr
    );
    modport slave (
        output ready, rd_data, rd_busy,
        input  rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits with registered per-port lookup
//   in : clk, rst_n (sync, active low), run (sweep done), wr_en/wr_addr (clears pending),
//        set_en/set_addr (marks pending), rd_addr (NUM_RD packed addresses)
//   out: rd_busy (registered pending flag per read port)
//   RF_BYPASS_EN: a same-edge write to the read address forwards its pending outcome
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic                 set_en,
    input  logic [AW-1:0]        set_addr,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]    rd_busy
);
    logic [DEPTH-1:0] pending, set_v, clr_v;
    logic             wr_ok, set_ok;

    assign wr_ok  = run && wr_en && !(ZERO_REG != 0 && wr_addr == '0);
    assign set_ok = run && set_en && !(ZERO_REG != 0 && set_addr == '0);
    assign set_v  = DEPTH'(set_ok) << set_addr;
    assign clr_v  = DEPTH'(wr_ok) << wr_addr;

    // set is applied after clear so a same-edge set and write leaves the register pending
    always_ff @(posedge clk)
        pending <= rst_n ? (set_v | (pending & ~clr_v)) : '0;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic          q;
        assign ra = rd_addr[p*AW +: AW];
        always_ff @(posedge clk)
`ifdef RF_BYPASS_EN
            q <= rst_n && run && ((wr_ok && wr_addr == ra) ? (set_ok && set_addr == ra) : pending[ra]);
`else
            q <= rst_n && run && pending[ra];
`endif
        assign rd_busy[p] = q;
    end
endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: DEPTH x DW register file, NUM_RD registered reads, one write, clear sweep
//   clk, rst_n (sync, active low) plain ports; bus (regfile_multiport_if.slave) carries
//   ready, rd_addr/rd_data/rd_busy, wr_en/wr_addr/wr_data, sb_set_en/sb_set_addr
//   RF_BYPASS_EN: same-edge write data is forwarded to matching read ports
module regfile_multiport #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic              clk,
    input logic              rst_n,
    regfile_multiport_if.slave bus
);
    import regfile_pkg::*;
    localparam int AW = clog2(DEPTH);

    rf_state_t     state;
    logic [AW-1:0] clr_idx, mem_addr;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_wdata;
    logic          run, wr_ok, mem_we, ready_q;

    assign run       = state == RF_RUN;
    assign wr_ok     = run && bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
    // the sweep borrows the write port until every entry is zeroed
    assign mem_we    = rst_n && (!run || wr_ok);
    assign mem_addr  = run ? bus.wr_addr : clr_idx;
    assign mem_wdata = run ? bus.wr_data : '0;
    assign bus.ready = ready_q;

    always_ff @(posedge clk)
        if (mem_we) mem[mem_addr] <= mem_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else if (!run) begin
            clr_idx <= clr_idx + AW'(1);
            if (clr_idx == AW'(DEPTH - 1)) begin
                state   <= RF_RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // with ZERO_REG, entry 0 is zeroed by the sweep and never written, so it reads 0 naturally
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] nxt, q;
        assign ra = bus.rd_addr[p*AW +: AW];
`ifdef RF_BYPASS_EN
        assign nxt = (wr_ok && bus.wr_addr == ra) ? bus.wr_data : mem[ra];
`else
        assign nxt = mem[ra];
`endif
        always_ff @(posedge clk)
            q <= (rst_n && run) ? nxt : '0;
        assign bus.rd_data[p*DW +: DW] = q;
    end

    regfile_scoreboard #(.DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .set_en  (bus.sb_set_en),
        .set_addr(bus.sb_set_addr),
        .rd_addr (bus.rd_addr),
        .rd_busy (bus.rd_busy)
    );
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: scoreboard bench for two register file configurations
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_multiport_if #(.DW(32), .DEPTH(32), .NUM_RD(2)) ia();
    regfile_multiport_if #(.DW(16), .DEPTH(16), .NUM_RD(4)) ib();

    regfile_multiport #(.DW(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia));
    regfile_multiport #(.DW(16), .DEPTH(16), .NUM_RD(4), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib));

    typedef struct {
        int          due;
        bit          b;
        bit          is_ready;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncmp = 0;
    int   nbad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        logic        bact;
        while (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            ncmp++;
            if (e.is_ready) begin
                act  = {31'b0, e.b ? ib.ready : ia.ready};
                bact = 1'b0;
            end else begin
                act  = e.b ? {16'b0, ib.rd_data[e.port*16 +: 16]} : ia.rd_data[e.port*32 +: 32];
                bact = e.b ? ib.rd_busy[e.port] : ia.rd_busy[e.port];
            end
            if (e.due != cyc || act !== e.data || bact !== e.busy) begin
                nbad++;
                $display("FAIL %s_%s port%0d cyc%0d(due %0d): got data=%h busy=%b, want data=%h busy=%b",
                         e.b ? "b" : "a", e.is_ready ? "ready" : "rd", e.port, cyc, e.due,
                         act, bact, e.data, e.busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ready(input bit b, input bit r, input int d);
        q.push_back('{due: cyc + d, b: b, is_ready: 1'b1, port: 0, data: 32'(r), busy: 1'b0});
    endtask

    task automatic expect_rd(input bit b, input int p, input logic [31:0] dat, input logic bz, input int d);
        q.push_back('{due: cyc + d, b: b, is_ready: 1'b0, port: p, data: dat, busy: bz});
    endtask

    task automatic idle_a();
        ia.wr_en = 1'b0; ia.wr_addr = '0; ia.wr_data = '0;
        ia.sb_set_en = 1'b0; ia.sb_set_addr = '0; ia.rd_addr = '0;
    endtask

    // one cycle on instance A: drive, queue the read results due after this edge, advance
    task automatic step_a(input bit we, input int wa, input logic [31:0] wd, input bit se, input int sa,
                          input int r0, input int r1,
                          input logic [31:0] e0, input logic b0, input logic [31:0] e1, input logic b1);
        ia.wr_en = we; ia.wr_addr = 5'(wa); ia.wr_data = wd;
        ia.sb_set_en = se; ia.sb_set_addr = 5'(sa);
        ia.rd_addr = {5'(r1), 5'(r0)};
        expect_rd(1'b0, 0, e0, b0, 1);
        expect_rd(1'b0, 1, e1, b1, 1);
        tick();
    endtask

    initial begin
        idle_a();
        ib.wr_en = 1'b0; ib.wr_addr = '0; ib.wr_data = '0;
        ib.sb_set_en = 1'b0; ib.sb_set_addr = '0; ib.rd_addr = '0;
        tick();
        tick();
        expect_ready(1'b0, 1'b0, 0);
        expect_ready(1'b1, 1'b0, 0);
        expect_rd(1'b0, 0, 32'h0, 1'b0, 0);
        expect_rd(1'b0, 1, 32'h0, 1'b0, 0);
        rst_n = 1'b1;

        // clear sweep: writes/sets during the last edges must be ignored, reads held at 0
        for (int i = 1; i <= 32; i++) begin
            if (i >= 30) begin
                ia.wr_en = 1'b1; ia.wr_addr = 5'd5; ia.wr_data = '1;
                ia.sb_set_en = 1'b1; ia.sb_set_addr = 5'd6;
                ia.rd_addr = {5'd6, 5'd5};
            end
            expect_ready(1'b0, i == 32, 1);
            if (i <= 20) expect_ready(1'b1, i >= 16, 1);
            expect_rd(1'b0, 0, 32'h0, 1'b0, 1);
            tick();
        end
        idle_a();

        for (int i = 0; i < 32; i++) step_a(0, 0, 0, 0, 0, i, 31 - i, 0, 0, 0, 0);

        step_a(1, 5, 32'hDEADBEEF, 0, 0, 5, 1, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0);
        step_a(1, 0, 32'h1234, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
        step_a(0, 0, 0, 0, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0);
        step_a(1, 7, 32'h11, 0, 0, 7, 7, BYP ? 32'h11 : 32'h0, 0, BYP ? 32'h11 : 32'h0, 0);
        step_a(1, 7, 32'hA5A5A5A5, 0, 0, 7, 7, BYP ? 32'hA5A5A5A5 : 32'h11, 0, BYP ? 32'hA5A5A5A5 : 32'h11, 0);
        step_a(0, 0, 0, 1, 3, 3, 7, 0, 0, 32'hA5A5A5A5, 0);
        step_a(0, 0, 0, 0, 0, 3, 3, 0, 1, 0, 1);
        step_a(1, 3, 32'h55, 0, 0, 3, 0, BYP ? 32'h55 : 32'h0, !BYP, 0, 0);
        step_a(0, 0, 0, 0, 0, 3, 5, 32'h55, 0, 32'hDEADBEEF, 0);
        step_a(1, 3, 32'h66, 1, 3, 3, 3, BYP ? 32'h66 : 32'h55, BYP, BYP ? 32'h66 : 32'h55, BYP);
        step_a(0, 0, 0, 0, 0, 3, 3, 32'h66, 1, 32'h66, 1);
        step_a(0, 0, 0, 1, 0, 0, 3, 0, 0, 32'h66, 1);
        step_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step_a(1, 3, 32'h77, 1, 9, 9, 3, 0, 0, BYP ? 32'h77 : 32'h66, !BYP);
        step_a(0, 0, 0, 0, 0, 9, 3, 0, 1, 32'h77, 0);
        idle_a();

        // reset while running, then again at sweep index 10
        rst_n = 1'b0;
        expect_ready(1'b0, 1'b0, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            expect_ready(1'b0, 1'b0, 1);
            tick();
        end
        rst_n = 1'b0;
        expect_ready(1'b0, 1'b0, 1);
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            expect_ready(1'b0, i == 32, 1);
            tick();
        end
        for (int i = 0; i < 32; i++) step_a(0, 0, 0, 0, 0, i, 31 - i, 0, 0, 0, 0);

        // wide-port instance: four ports on distinct registers
        for (int i = 1; i <= 4; i++) begin
            ib.wr_en = 1'b1; ib.wr_addr = 4'(i); ib.wr_data = 16'(i);
            tick();
        end
        ib.wr_en = 1'b0;
        ib.rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
        expect_ready(1'b1, 1'b1, 1);
        for (int p = 0; p < 4; p++) expect_rd(1'b1, p, 32'(p + 1), 1'b0, 1);
        tick();
        ib.rd_addr = {4'd1, 4'd2, 4'd3, 4'd0};
        expect_rd(1'b1, 0, 32'h0, 1'b0, 1);
        expect_rd(1'b1, 1, 32'h3, 1'b0, 1);
        expect_rd(1'b1, 2, 32'h2, 1'b0, 1);
        expect_rd(1'b1, 3, 32'h1, 1'b0, 1);
        tick();

        tick();
        tick();
        if (q.size() != 0) begin
            nbad++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end
endmodule
